// File: rtl/chacha20_stream_buf.sv
// -----------------------------------------------------------------------------
// chacha20_stream_buf
//
// Keystream buffer between the ChaCha20 core and the XOR datapath. It
// prefetches 512-bit keystream blocks into a two-slot ping-pong buffer and
// drains them as DATA_W-bit words over a valid/ready stream. The next block is
// fetched while the current one drains. A programmable initial block counter
// is loaded on i_key_reload. A request that is not answered within TIMEOUT
// cycles raises a sticky error.
//
// Ports
//   i_aclk, i_aresetn           clock, asynchronous active-low reset
//   i_enable                    permit new block requests
//   i_key_reload                one-cycle flush/restart, loads i_counter_init
//   i_counter_init              block counter loaded on reload
//   o_error                     sticky request timeout error
//   o_chacha20_req              one-cycle request pulse to the core
//   i_chacha20_busy             core busy, no request issued while high
//   o_chacha20_counter          block counter for the current/next request
//   i_chacha20_keystream_data   512-bit block from the core
//   i_chacha20_keystream_valid  one-cycle block strobe
//   o_keystream_data/_valid     output word stream (word 0 = bits [DATA_W-1:0])
//   i_keystream_ready           consumer accepts the current word
//   o_keystream_available       at least one slot full
//   o_blocks_buffered           number of full slots, 0..2
// -----------------------------------------------------------------------------
module chacha20_stream_buf #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_aclk,
    input  logic              i_aresetn,
    input  logic              i_enable,
    input  logic              i_key_reload,
    input  logic [31:0]       i_counter_init,
    output logic              o_error,
    output logic              o_chacha20_req,
    input  logic              i_chacha20_busy,
    output logic [31:0]       o_chacha20_counter,
    input  logic [511:0]      i_chacha20_keystream_data,
    input  logic              i_chacha20_keystream_valid,
    output logic [DATA_W-1:0] o_keystream_data,
    output logic              o_keystream_valid,
    input  logic              i_keystream_ready,
    output logic              o_keystream_available,
    output logic [1:0]        o_blocks_buffered
);

    localparam int WORDS = 512 / DATA_W;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } fetch_state_e;

    fetch_state_e     state_q, state_d;
    logic [511:0]     slot0_q, slot0_d;
    logic [511:0]     slot1_q, slot1_d;
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [1:0]       count_q, count_d;
    logic [31:0]      counter_q, counter_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             error_q, error_d;

    logic              xfer_s;
    logic              last_s;
    logic              capture_s;
    logic [511:0]      cur_blk_s;
    logic [DATA_W-1:0] data_s;

    // Handshake qualifiers; a block arriving outside WAIT or during reload is dropped.
    always_comb begin
        xfer_s    = (count_q != 2'd0) && i_keystream_ready;
        last_s    = xfer_s && (idx_q == IDX_W'(WORDS - 1));
        capture_s = (state_q == ST_WAIT) && i_chacha20_keystream_valid && !i_key_reload;
    end

    // Fetch FSM, slot capture, drain pointers and occupancy; reload overrides all.
    always_comb begin
        state_d   = state_q;
        slot0_d   = slot0_q;
        slot1_d   = slot1_q;
        wr_d      = wr_q;
        rd_d      = rd_q;
        idx_d     = idx_q;
        count_d   = count_q;
        counter_d = counter_q;
        timer_d   = timer_q;
        error_d   = error_q;

        case (state_q)
            // No fill is pending while in IDLE, so the occupancy alone gates a request.
            ST_IDLE: begin
                if (i_enable && !i_chacha20_busy && (count_q < 2'd2) && !error_q) begin
                    state_d = ST_REQ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_REQ: begin
                timer_d = '0;
                state_d = ST_WAIT;
            end
            // Timer is 0 in the first WAIT cycle, so firing at TIMEOUT-2 makes
            // o_error visible exactly TIMEOUT cycles after the REQ cycle.
            ST_WAIT: begin
                if (capture_s) begin
                    counter_d = counter_q + 32'd1;
                    state_d   = ST_IDLE;
                end else if (timer_q == TMR_W'(TIMEOUT - 2)) begin
                    error_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (capture_s) begin
            if (wr_q) begin
                slot1_d = i_chacha20_keystream_data;
            end else begin
                slot0_d = i_chacha20_keystream_data;
            end
            wr_d = ~wr_q;
        end else begin
            wr_d = wr_q;
        end

        if (last_s) begin
            idx_d = '0;
            rd_d  = ~rd_q;
        end else if (xfer_s) begin
            idx_d = idx_q + IDX_W'(1);
        end else begin
            idx_d = idx_q;
        end

        // A capture coinciding with the final-word transfer leaves count unchanged.
        case ({capture_s, last_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (i_key_reload) begin
            state_d   = ST_IDLE;
            count_d   = 2'd0;
            idx_d     = '0;
            wr_d      = 1'b0;
            rd_d      = 1'b0;
            counter_d = i_counter_init;
            timer_d   = '0;
            error_d   = 1'b0;
        end else begin
            error_d = error_d;
        end
    end

    // Select the current word out of the block under the read pointer.
    always_comb begin
        cur_blk_s = rd_q ? slot1_q : slot0_q;
        data_s    = '0;
        for (int w = 0; w < WORDS; w++) begin
            if (idx_q == IDX_W'(w)) begin
                data_s = cur_blk_s[w*DATA_W +: DATA_W];
            end else begin
                data_s = data_s;
            end
        end
    end

    // State registers with asynchronous reset; slots are cleared so data reads 0.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q   <= ST_IDLE;
            slot0_q   <= '0;
            slot1_q   <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            idx_q     <= '0;
            count_q   <= 2'd0;
            counter_q <= 32'd0;
            timer_q   <= '0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot0_q   <= slot0_d;
            slot1_q   <= slot1_d;
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            idx_q     <= idx_d;
            count_q   <= count_d;
            counter_q <= counter_d;
            timer_q   <= timer_d;
            error_q   <= error_d;
        end
    end

    assign o_error               = error_q;
    assign o_chacha20_req        = (state_q == ST_REQ);
    assign o_chacha20_counter    = counter_q;
    assign o_keystream_data      = data_s;
    assign o_keystream_valid     = (count_q != 2'd0);
    assign o_keystream_available = (count_q != 2'd0);
    assign o_blocks_buffered     = count_q;

endmodule

// File: tb/tb_chacha20_stream_buf.sv
// -----------------------------------------------------------------------------
// tb_chacha20_stream_buf
//
// Directed bench for chacha20_stream_buf. DUT "a" uses DATA_W=32, DUT "b" uses
// DATA_W=128; both use TIMEOUT=16 and share clock, reset, reload and the core
// return bus. Only the DUT whose i_enable is high ever requests a block, so the
// other one stays idle and drops the shared keystream strobe.
// -----------------------------------------------------------------------------
module tb_chacha20_stream_buf;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         key_reload;
    logic [31:0]  counter_init;
    logic         busy;
    logic [511:0] ks_data;
    logic         ks_valid;

    logic         en_a, rdy_a, err_a, req_a, vld_a, avail_a;
    logic [31:0]  cnt_a, data_a;
    logic [1:0]   buf_a;

    logic         en_b, rdy_b, err_b, req_b, vld_b, avail_b;
    logic [31:0]  cnt_b;
    logic [127:0] data_b;
    logic [1:0]   buf_b;

    int n_tests = 0;
    int n_fail  = 0;

    logic [511:0] blk0, blk1;

    always #5 clk = ~clk;

    chacha20_stream_buf #(.DATA_W(32), .TIMEOUT(16)) u_dut_a (
        .i_aclk(clk), .i_aresetn(rst_n), .i_enable(en_a), .i_key_reload(key_reload),
        .i_counter_init(counter_init), .o_error(err_a), .o_chacha20_req(req_a),
        .i_chacha20_busy(busy), .o_chacha20_counter(cnt_a),
        .i_chacha20_keystream_data(ks_data), .i_chacha20_keystream_valid(ks_valid),
        .o_keystream_data(data_a), .o_keystream_valid(vld_a), .i_keystream_ready(rdy_a),
        .o_keystream_available(avail_a), .o_blocks_buffered(buf_a)
    );

    chacha20_stream_buf #(.DATA_W(128), .TIMEOUT(16)) u_dut_b (
        .i_aclk(clk), .i_aresetn(rst_n), .i_enable(en_b), .i_key_reload(key_reload),
        .i_counter_init(counter_init), .o_error(err_b), .o_chacha20_req(req_b),
        .i_chacha20_busy(busy), .o_chacha20_counter(cnt_b),
        .i_chacha20_keystream_data(ks_data), .i_chacha20_keystream_valid(ks_valid),
        .o_keystream_data(data_b), .o_keystream_valid(vld_b), .i_keystream_ready(rdy_b),
        .o_keystream_available(avail_b), .o_blocks_buffered(buf_b)
    );

    // Block whose 32-bit word i equals base + i.
    function automatic logic [511:0] make_block(input logic [31:0] base);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[i*32 +: 32] = base + 32'(i);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reload(input logic [31:0] init);
        counter_init = init;
        key_reload   = 1'b1;
        step();
        key_reload   = 1'b0;
    endtask

    task automatic wait_req_a(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_a === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL %s: got no request, expected req within 40 cycles", name); end
    endtask

    task automatic wait_req_b(input string name);
        bit got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (req_b === 1'b1) begin
                got = 1'b1;
                break;
            end
            step();
        end
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL %s: got no request, expected req within 40 cycles", name); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; key_reload = 1'b0; counter_init = 32'd0; busy = 1'b0;
        ks_data = 512'd0; ks_valid = 1'b0;
        en_a = 1'b0; rdy_a = 1'b0; en_b = 1'b0; rdy_b = 1'b0;
        step();
        step();
        n_tests++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %0h expected 0", err_a); end
        n_tests++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL rst_req: got %0h expected 0", req_a); end
        n_tests++; if (cnt_a !== 32'd0) begin n_fail++; $display("FAIL rst_counter: got %0h expected 0", cnt_a); end
        n_tests++; if (data_a !== 32'd0) begin n_fail++; $display("FAIL rst_data: got %0h expected 0", data_a); end
        n_tests++; if (vld_a !== 1'b0 || avail_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0h/%0h expected 0/0", vld_a, avail_a); end
        n_tests++; if (buf_a !== 2'd0 || data_b !== 128'd0) begin n_fail++; $display("FAIL rst_buf: got %0h/%0h expected 0/0", buf_a, data_b); end
    endtask

    // Cycle 0 = first cycle out of reset with enable high; core answers at cycle 11.
    task automatic test_stream();
        logic [31:0] exp_w;
        rst_n = 1'b1; en_a = 1'b1; rdy_a = 1'b1;
        step();
        n_tests++; if (req_a !== 1'b1 || cnt_a !== 32'd0) begin n_fail++; $display("FAIL stream_req0: got req %0h cnt %0h expected 1/0", req_a, cnt_a); end
        step();
        n_tests++; if (req_a !== 1'b0) begin n_fail++; $display("FAIL stream_req_pulse: got %0h expected 0", req_a); end
        for (int c = 2; c < 11; c++) step();
        ks_valid = 1'b1; ks_data = blk0;
        step();
        for (int k = 0; k < 32; k++) begin
            ks_valid = (k == 8);
            ks_data  = (k == 8) ? blk1 : 512'd0;
            exp_w = (k < 16) ? (32'hB000_0000 + 32'(k)) : (32'hB100_0000 + 32'(k - 16));
            n_tests++; if (vld_a !== 1'b1 || data_a !== exp_w) begin n_fail++; $display("FAIL stream_word%0d: got v=%0h d=%0h expected v=1 d=%0h", k, vld_a, data_a, exp_w); end
            if (k == 1) begin
                n_tests++; if (req_a !== 1'b1 || cnt_a !== 32'd1) begin n_fail++; $display("FAIL stream_req1: got req %0h cnt %0h expected 1/1", req_a, cnt_a); end
            end
            if (k == 9) begin
                n_tests++; if (cnt_a !== 32'd2 || buf_a !== 2'd2) begin n_fail++; $display("FAIL stream_cnt2: got cnt %0h buf %0h expected 2/2", cnt_a, buf_a); end
            end
            if (k == 17) begin
                n_tests++; if (req_a !== 1'b1 || cnt_a !== 32'd2) begin n_fail++; $display("FAIL stream_req2: got req %0h cnt %0h expected 1/2", req_a, cnt_a); end
            end
            step();
        end
        ks_valid = 1'b0;
        n_tests++; if (vld_a !== 1'b0 || buf_a !== 2'd0) begin n_fail++; $display("FAIL stream_empty: got v=%0h buf=%0h expected 0/0", vld_a, buf_a); end
    endtask

    task automatic test_hold();
        rdy_a = 1'b0;
        pulse_reload(32'd0);
        wait_req_a("hold_req0");
        step();
        ks_valid = 1'b1; ks_data = blk0;
        step();
        ks_valid = 1'b0;
        wait_req_a("hold_req1");
        step();
        ks_valid = 1'b1; ks_data = blk1;
        step();
        ks_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (vld_a !== 1'b1 || data_a !== 32'hB000_0000) begin n_fail++; $display("FAIL hold_data%0d: got v=%0h d=%0h expected v=1 d=b0000000", i, vld_a, data_a); end
            n_tests++; if (buf_a !== 2'd2 || req_a !== 1'b0 || cnt_a !== 32'd2) begin n_fail++; $display("FAIL hold_full%0d: got buf %0h req %0h cnt %0h expected 2/0/2", i, buf_a, req_a, cnt_a); end
            step();
        end
    endtask

    // DATA_W=128: ready alternates 1,0,...; the fourth word leaves in the cycle the next block lands.
    task automatic test_backpressure_boundary();
        logic [127:0] exp_w;
        int           widx;
        en_a = 1'b0; en_b = 1'b1; rdy_b = 1'b0;
        pulse_reload(32'd0);
        wait_req_b("bp_req0");
        step();
        ks_valid = 1'b1; ks_data = blk0;
        step();
        for (int k = 0; k < 7; k++) begin
            rdy_b    = (k % 2 == 0);
            ks_valid = (k == 6);
            ks_data  = (k == 6) ? blk1 : 512'd0;
            widx     = (k + 1) / 2;
            exp_w    = blk0[widx*128 +: 128];
            n_tests++; if (vld_b !== 1'b1 || data_b !== exp_w || buf_b !== 2'd1) begin n_fail++; $display("FAIL bp_word_k%0d: got v=%0h buf=%0h d=%0h expected v=1 buf=1 d=%0h", k, vld_b, buf_b, data_b, exp_w); end
            step();
        end
        ks_valid = 1'b0; rdy_b = 1'b0;
        exp_w = blk1[127:0];
        n_tests++; if (vld_b !== 1'b1 || buf_b !== 2'd1 || data_b !== exp_w) begin n_fail++; $display("FAIL bp_boundary: got v=%0h buf=%0h d=%0h expected v=1 buf=1 d=%0h", vld_b, buf_b, data_b, exp_w); end
    endtask

    task automatic test_timeout();
        en_b = 1'b0; en_a = 1'b1; rdy_a = 1'b0;
        pulse_reload(32'd0);
        wait_req_a("to_req");
        for (int i = 1; i < 16; i++) begin
            step();
            n_tests++; if (err_a !== 1'b0 || req_a !== 1'b0) begin n_fail++; $display("FAIL to_early%0d: got err %0h req %0h expected 0/0", i, err_a, req_a); end
        end
        step();
        n_tests++; if (err_a !== 1'b1) begin n_fail++; $display("FAIL to_error: got %0h expected 1", err_a); end
        for (int i = 0; i < 10; i++) begin
            step();
            n_tests++; if (req_a !== 1'b0 || err_a !== 1'b1 || cnt_a !== 32'd0) begin n_fail++; $display("FAIL to_sticky%0d: got req %0h err %0h cnt %0h expected 0/1/0", i, req_a, err_a, cnt_a); end
        end
        pulse_reload(32'hFFFF_FFFF);
        n_tests++; if (err_a !== 1'b0 || cnt_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_reload: got err %0h cnt %0h expected 0/ffffffff", err_a, cnt_a); end
        wait_req_a("to_req_after");
        n_tests++; if (cnt_a !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL to_cnt_req: got %0h expected ffffffff", cnt_a); end
        step();
        ks_valid = 1'b1; ks_data = blk0;
        step();
        ks_valid = 1'b0;
        n_tests++; if (cnt_a !== 32'd0 || buf_a !== 2'd1) begin n_fail++; $display("FAIL to_cnt_wrap: got cnt %0h buf %0h expected 0/1", cnt_a, buf_a); end
    endtask

    task automatic test_reload_in_wait();
        wait_req_a("rl_req");
        step();
        n_tests++; if (buf_a !== 2'd1 || vld_a !== 1'b1) begin n_fail++; $display("FAIL rl_pre: got buf %0h v %0h expected 1/1", buf_a, vld_a); end
        key_reload = 1'b1; en_a = 1'b0; counter_init = 32'd0;
        step();
        key_reload = 1'b0;
        n_tests++; if (vld_a !== 1'b0 || buf_a !== 2'd0) begin n_fail++; $display("FAIL rl_drop: got v %0h buf %0h expected 0/0", vld_a, buf_a); end
        ks_valid = 1'b1; ks_data = blk1;
        step();
        ks_valid = 1'b0;
        n_tests++; if (vld_a !== 1'b0 || buf_a !== 2'd0 || req_a !== 1'b0) begin n_fail++; $display("FAIL rl_late: got v %0h buf %0h req %0h expected 0/0/0", vld_a, buf_a, req_a); end
    endtask

    task automatic test_async_reset();
        en_a = 1'b1; rdy_a = 1'b1;
        pulse_reload(32'd5);
        wait_req_a("ar_req");
        n_tests++; if (cnt_a !== 32'd5) begin n_fail++; $display("FAIL ar_cnt: got %0h expected 5", cnt_a); end
        step();
        ks_valid = 1'b1; ks_data = blk0;
        step();
        ks_valid = 1'b0;
        step();
        step();
        n_tests++; if (vld_a !== 1'b1 || data_a !== 32'hB000_0002 || cnt_a !== 32'd6) begin n_fail++; $display("FAIL ar_mid: got v %0h d %0h cnt %0h expected 1/b0000002/6", vld_a, data_a, cnt_a); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (vld_a !== 1'b0 || avail_a !== 1'b0 || buf_a !== 2'd0) begin n_fail++; $display("FAIL ar_valid: got v %0h a %0h buf %0h expected 0/0/0", vld_a, avail_a, buf_a); end
        n_tests++; if (data_a !== 32'd0 || cnt_a !== 32'd0) begin n_fail++; $display("FAIL ar_data: got d %0h cnt %0h expected 0/0", data_a, cnt_a); end
        n_tests++; if (err_a !== 1'b0 || req_a !== 1'b0) begin n_fail++; $display("FAIL ar_err: got err %0h req %0h expected 0/0", err_a, req_a); end
        #3;
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        blk0 = make_block(32'hB000_0000);
        blk1 = make_block(32'hB100_0000);
        test_reset();
        test_stream();
        test_hold();
        test_backpressure_boundary();
        test_timeout();
        test_reload_in_wait();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout at %0t, expected completion", $time);
        $fatal(1, "watchdog");
    end

endmodule
